// File: rtl/rho_unit.sv
// rho_unit: streams one 25-lane Keccak state through rho / inverse rho.
// Ports: clk, rst_n, mode_i, flush_i, in_valid/ready/lanes, out_valid/ready/lanes/last.
module rho_unit #(
    parameter int LANE_W         = 64,
    parameter int LANES_PER_BEAT = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mode_i,
    input  logic                             flush_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [LANES_PER_BEAT*LANE_W-1:0] in_lanes_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [LANES_PER_BEAT*LANE_W-1:0] out_lanes_o,
    output logic                             out_last_o
);
    localparam int BEATS = 25 / LANES_PER_BEAT;
    localparam int RW    = $clog2(LANE_W);
    localparam int DW    = LANES_PER_BEAT * LANE_W;

    generate
        if (!(LANES_PER_BEAT == 1 || LANES_PER_BEAT == 5 || LANES_PER_BEAT == 25) ||
            !(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_param
            $error("rho_unit: illegal LANE_W / LANES_PER_BEAT");
        end
    endgenerate

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q;
    logic [4:0]      beat_q;
    logic            mode_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [DW-1:0]   out_lanes_q;
    logic [DW-1:0]   rot_d;
    logic            eff_mode;
    logic            last_beat;
    logic            accept;

    // Offset for global lane k = 5*x + y.
    function automatic logic [5:0] off_of(input logic [4:0] k);
        logic [5:0] o;
        case (k)
            5'd0:  o = 6'd0;   5'd1:  o = 6'd36;  5'd2:  o = 6'd3;
            5'd3:  o = 6'd41;  5'd4:  o = 6'd18;  5'd5:  o = 6'd1;
            5'd6:  o = 6'd44;  5'd7:  o = 6'd10;  5'd8:  o = 6'd45;
            5'd9:  o = 6'd2;   5'd10: o = 6'd62;  5'd11: o = 6'd6;
            5'd12: o = 6'd43;  5'd13: o = 6'd15;  5'd14: o = 6'd61;
            5'd15: o = 6'd28;  5'd16: o = 6'd55;  5'd17: o = 6'd25;
            5'd18: o = 6'd21;  5'd19: o = 6'd56;  5'd20: o = 6'd27;
            5'd21: o = 6'd20;  5'd22: o = 6'd39;  5'd23: o = 6'd8;
            5'd24: o = 6'd14;  default: o = 6'd0;
        endcase
        return o;
    endfunction

    // Rotation through a doubled lane, so r = 0 never needs a shift by LANE_W.
    function automatic logic [LANE_W-1:0] rot(
        input logic [LANE_W-1:0] x,
        input logic [RW-1:0]     r,
        input logic              right
    );
        logic [2*LANE_W-1:0] dbl;
        dbl = {x, x};
        if (right) begin
            dbl = dbl >> r;
            return dbl[LANE_W-1:0];
        end
        dbl = dbl << r;
        return dbl[2*LANE_W-1:LANE_W];
    endfunction

    // In IDLE the incoming beat is beat 0, so the live mode_i applies.
    assign eff_mode   = (state_q == IDLE) ? mode_i : mode_q;
    assign last_beat  = (beat_q == 5'(BEATS - 1));
    assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        rot_d = '0;
        for (int j = 0; j < LANES_PER_BEAT; j++) begin
            rot_d[j*LANE_W +: LANE_W] = rot(
                in_lanes_i[j*LANE_W +: LANE_W],
                RW'(off_of(beat_q * 5'(LANES_PER_BEAT) + 5'(j))),
                eff_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_lanes_q <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_lanes_q <= rot_d;
            out_last_q  <= last_beat;
            out_valid_q <= 1'b1;
            beat_q      <= last_beat ? 5'd0 : beat_q + 5'd1;
            if (state_q == IDLE) begin
                mode_q <= mode_i;
            end
            state_q <= (BEATS > 1 && !last_beat) ? BUSY : IDLE;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_lanes_o = out_lanes_q;

endmodule

// File: tb/tb_rho_unit.sv
// tb_rho_unit: scoreboard bench for rho_unit.
// Two instances: 64-bit x5 lanes and 8-bit x1 lane.
module tb_rho_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] mode, flush, iv, ordy, ir, ov, olast;
  logic [319:0] in0, out0;
  logic [7:0] in1, out1;

  rho_unit #(.LANE_W(64), .LANES_PER_BEAT(5)) u0 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode[0]), .flush_i(flush[0]),
    .in_valid_i(iv[0]), .in_ready_o(ir[0]), .in_lanes_i(in0),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .out_lanes_o(out0),
    .out_last_o(olast[0]));

  rho_unit #(.LANE_W(8), .LANES_PER_BEAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode[1]), .flush_i(flush[1]),
    .in_valid_i(iv[1]), .in_ready_o(ir[1]), .in_lanes_i(in1),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .out_lanes_o(out1),
    .out_last_o(olast[1]));

  typedef struct {
    logic [319:0] d;
    bit last;
  } exp_t;

  int errs = 0;
  int checks = 0;

  int OFF[5][5] = '{'{0, 36, 3, 41, 18}, '{1, 44, 10, 45, 2},
                    '{62, 6, 43, 15, 61}, '{28, 55, 25, 21, 56},
                    '{27, 20, 39, 8, 14}};
  int W_[2] = '{64, 8};
  int LP_[2] = '{5, 1};
  int BT_[2] = '{5, 25};

  exp_t q0[$];
  exp_t q1[$];
  int mb[2];
  bit mm[2];
  bit rt_on = 0;
  bit cap_on = 0;
  logic [319:0] rt_exp[$];
  logic [319:0] cap[$];

  bit st[2];
  logic [319:0] sd[2];
  logic sl[2];

  task automatic chk(input bit ok, input string nm,
                     input logic [319:0] a, input logic [319:0] b);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, a, b);
    end
  endtask

  // Reference: bit i of lane k moves to (i +/- r) mod w.
  function automatic logic [319:0] ref_beat(input logic [319:0] din,
      input int d, input int beat, input bit md);
    logic [319:0] o;
    int w, k, r;
    o = '0;
    w = W_[d];
    for (int j = 0; j < LP_[d]; j++) begin
      k = beat * LP_[d] + j;
      r = OFF[k / 5][k % 5] % w;
      for (int i = 0; i < w; i++) begin
        if (!md) o[j*w + (i + r) % w] = din[j*w + i];
        else o[j*w + (i + w - r) % w] = din[j*w + i];
      end
    end
    return o;
  endfunction

  task automatic accept(input int d);
    exp_t e;
    logic [319:0] din;
    din = (d == 1) ? 320'(in1) : in0;
    if (mb[d] == 0) mm[d] = mode[d];
    if (d == 0 && rt_on) e.d = rt_exp.pop_front();
    else e.d = ref_beat(din, d, mb[d], mm[d]);
    e.last = (mb[d] == BT_[d] - 1);
    mb[d] = (mb[d] + 1) % BT_[d];
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Inputs are set at posedge+1; acceptance is decided at the negedge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ov[d] && !ordy[d])
        chk(ir[d] == 1'b0, "ready_stall", 320'(ir[d]), 320'(0));
      if (flush[d]) begin
        chk(ir[d] == 1'b0, "ready_flush", 320'(ir[d]), 320'(0));
        mb[d] = 0;
      end else if (iv[d] && ir[d]) begin
        accept(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every beat that downstream consumes.
  always @(negedge clk) begin
    logic [319:0] o;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      o = (d == 1) ? 320'(out1) : out0;
      if (st[d] && rst_n)
        chk(ov[d] && o == sd[d] && olast[d] == sl[d], "stall_hold", o, sd[d]);
      if (ov[d] && ordy[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk(1'b0, "unexpected_out", o, 320'(0));
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk(o == e.d, d == 0 ? "lanes_u0" : "lanes_u1", o, e.d);
          chk(olast[d] == e.last, "last", 320'(olast[d]), 320'(e.last));
          if (d == 0 && cap_on) cap.push_back(o);
        end
      end
      st[d] = ov[d] && !ordy[d];
      sd[d] = o;
      sl[d] = olast[d];
    end
  end

  task automatic rnd0();
    for (int i = 0; i < 10; i++) in0[i*32 +: 32] = $urandom;
  endtask

  initial begin
    logic [319:0] orig;
    mode = '0; flush = '0; iv = '0; ordy = '0;
    in0 = '0; in1 = '0;
    mb = '{0, 0}; mm = '{0, 0}; st = '{0, 0};
    #1 rst_n = 1'b0;
    #1;
    chk(ov == 2'b00, "reset_valid", 320'(ov), 320'(0));
    chk(olast == 2'b00, "reset_last", 320'(olast), 320'(0));
    chk(out0 == '0 && out1 == '0, "reset_lanes", out0, 320'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(ir == 2'b11, "ready_after_reset", 320'(ir), 320'(3));

    // Directed: all-ones lanes, forward then inverse.
    ordy = 2'b11; iv = 2'b11;
    in0 = {5{64'h1}}; in1 = 8'h01;
    repeat (25) tick();
    mode = 2'b11;
    repeat (25) tick();

    // Random traffic with backpressure, mode toggles and flushes.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = ($urandom_range(0, 3) != 0);
        ordy[d] = $urandom_range(0, 1);
        mode[d] = $urandom_range(0, 1);
        flush[d] = ($urandom_range(0, 60) == 0);
        if (flush[d]) ordy[d] = 1'b1;
      end
      rnd0();
      in1 = 8'($urandom);
      tick();
    end

    // Flush after beat 2, then a full state.
    iv = '0; ordy = 2'b11; flush = 2'b11;
    tick();
    flush = '0; iv = 2'b11; mode = 2'b00;
    repeat (3) begin rnd0(); in1 = 8'($urandom); tick(); end
    iv = 2'b11; flush = 2'b11;
    tick();
    flush = '0;
    repeat (5) begin rnd0(); in1 = 8'($urandom); mode = ~mode; tick(); end

    // Reset mid-state with u0 stalled.
    ordy = 2'b10;
    repeat (3) begin rnd0(); in1 = 8'($urandom); tick(); end
    #1 rst_n = 1'b0;
    #1;
    chk(ov == 2'b00, "reset_async_valid", 320'(ov), 320'(0));
    q0.delete(); q1.delete();
    mb = '{0, 0}; mm = '{0, 0}; st = '{0, 0};
    iv = '0; ordy = 2'b11;
    tick();
    #1 rst_n = 1'b1;
    tick();
    chk(ir == 2'b11, "ready_after_reset2", 320'(ir), 320'(3));
    iv = 2'b11; mode = 2'b01;
    repeat (25) begin rnd0(); in1 = 8'($urandom); tick(); end

    // Round trip on u0: forward, then feed outputs back inverse.
    iv = '0;
    repeat (3) tick();
    cap.delete();
    cap_on = 1;
    iv = 2'b01; mode = 2'b00;
    repeat (5) begin
      rnd0();
      rt_exp.push_back(in0);
      tick();
    end
    iv = '0;
    repeat (3) tick();
    cap_on = 0;
    chk(cap.size() == 5, "rt_capture", 320'(cap.size()), 320'(5));
    rt_on = 1;
    iv = 2'b01; mode = 2'b01;
    while (cap.size() > 0) begin
      in0 = cap.pop_front();
      tick();
      mode[0] = 1'b0;
    end
    iv = '0;
    repeat (3) tick();
    rt_on = 0;

    // Drain with a bounded wait.
    ordy = 2'b11;
    for (int c = 0; c < 50 && (q0.size() + q1.size()) > 0; c++) tick();
    chk(q0.size() == 0 && q1.size() == 0, "drain",
        320'(q0.size() + q1.size()), 320'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rho_unit.md
RHO_UNIT -- requirements
Module: rho_unit

Interface
REQ-001 SHALL have parameter LANE_W, default 64, the lane width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter LANES_PER_BEAT, default 5, the number of lanes per transfer; legal values 1, 5, 25; any other value fails elaboration.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port mode_i, input, 1 bit: 0 = rho (rotate left), 1 = inverse rho (rotate right).
REQ-006 SHALL have port flush_i, input, 1 bit, synchronous abort of the current state.
REQ-007 SHALL have port in_valid_i, input, 1 bit, input beat valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit, input beat accepted when high together with in_valid_i.
REQ-009 SHALL have port in_lanes_i, input, LANES_PER_BEAT*LANE_W bits; lane j occupies bits [j*LANE_W +: LANE_W].
REQ-010 SHALL have port out_valid_o, output, 1 bit, output beat valid.
REQ-011 SHALL have port out_ready_i, input, 1 bit, downstream accept.
REQ-012 SHALL have port out_lanes_o, output, LANES_PER_BEAT*LANE_W bits, rotated lanes in the same packing as in_lanes_i.
REQ-013 SHALL have port out_last_o, output, 1 bit, high on the final beat of a 25-lane state.

Function
REQ-014 SHALL stream one Keccak state as BEATS = 25/LANES_PER_BEAT beats; global lane index k = beat*LANES_PER_BEAT + j, with x = k/5 and y = k%5.
REQ-015 SHALL use offset table OFF[x][y] (x = row, y = column): x0 {0,36,3,41,18}; x1 {1,44,10,45,2}; x2 {62,6,43,15,61}; x3 {28,55,25,21,56}; x4 {27,20,39,8,14}.
REQ-016 SHALL use effective offset r = OFF[x][y] mod LANE_W.
REQ-017 SHALL output lane k rotated left by r when the latched mode = 0, and rotated right by r when it = 1; r = 0 passes the lane unchanged, with no shift by LANE_W.
REQ-018 SHALL keep a beat counter (0..BEATS-1): increment on each accepted input beat, wrap to 0 after beat BEATS-1.
REQ-019 SHALL implement FSM IDLE/BUSY:
- IDLE -> BUSY on an accepted beat when BEATS > 1.
- BUSY -> IDLE on acceptance of beat BEATS-1.
- With BEATS = 1, the FSM stays in IDLE and every beat is a full state.
REQ-020 SHALL latch mode_i on the accepted beat 0 and apply it to all beats of that state; mode_i changes in BUSY are ignored.
REQ-021 SHALL register the output: exactly 1 cycle of latency from input acceptance to out_valid_o.
REQ-022 SHALL drive in_ready_o = !out_valid_o || out_ready_i (combinational), giving full throughput of one beat per cycle with no bubbles.
REQ-023 SHALL hold out_lanes_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL assert out_last_o exactly on the output beat derived from input beat BEATS-1.
REQ-025 SHALL, on flush_i=1 at a clock edge:
- clear out_valid_o, the beat counter, and the FSM (to IDLE);
- discard any input beat presented in that cycle.
- in_ready_o is driven 0 while flush_i=1.
REQ-026 SHALL, on simultaneous output consume and input accept, load the new beat into the output register in the same cycle.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously force:
- out_valid_o=0, out_last_o=0, out_lanes_o=0;
- beat counter = 0, FSM = IDLE, latched mode = 0.
REQ-028 SHALL drive in_ready_o=1 one cycle after rst_n deasserts, with no further wait state.
REQ-029 SHALL discard a partially streamed state when reset is asserted mid-state; the next accepted beat is beat 0.

Verification
REQ-030 Forward rotation, LANE_W=64, LANES_PER_BEAT=5, mode 0: beat 0 with all lanes 64'h1 -> 64'h1, 1<<36, 1<<3, 1<<41, 1<<18, out_last_o=0; beats 1-4 each with all lanes 64'h1 -> rows x1-x4 rotated per table, out_last_o=1 on beat 4 only.
REQ-031 Reduced width and inverse, LANE_W=8: lane (0,1)=8'h01, mode 0 -> 8'h10 (36 mod 8 = 4); same input with mode 1 -> 8'h10; lane (1,0)=8'h01, mode 1 -> 8'h80.
REQ-032 Round trip, LANE_W=64, LANES_PER_BEAT=25: random state through mode 0, output fed back with mode 1 -> bit-exact original; out_last_o=1 on every beat.
REQ-033 Backpressure, LANE_W=64, LANES_PER_BEAT=1, random out_ready_i (50%): 25 beats -> in_ready_o=0 while output stalled, outputs unchanged while stalled, no beat lost or duplicated, out_last_o only on beat 24.
REQ-034 Abort and reset:
- flush_i pulsed after beat 2 of 5 -> next beat processed as beat 0 with row x0 offsets.
- rst_n pulsed low mid-state -> out_valid_o=0 immediately, and the next state starts at beat 0.
REQ-035 Mode latching, LANES_PER_BEAT=5: mode_i toggled on beats 1-4 -> all beats use the beat-0 mode.
